// File: rtl/stream_mux_rr_pkg.sv
// stream_mux_pkg: mode encodings and counter width shared by the stream_mux_rr slice.
package stream_mux_pkg;
  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR = 1'b1;
  localparam int XFER_CNT_W = 16;
endpackage

// File: rtl/stream_mux_rr_if.sv
// stream_mux_rr_if: N-channel input streams, select controls and the registered output stream.
interface stream_mux_rr_if #(
  parameter int NUM_CH = 16,
  parameter int WIDTH = 8
);
  localparam int SEL_W = $clog2(NUM_CH);
  logic mode;
  logic [SEL_W-1:0] sel;
  logic [NUM_CH*WIDTH-1:0] in_data;
  logic [NUM_CH-1:0] in_valid;
  logic [NUM_CH-1:0] in_ready;
  logic [WIDTH-1:0] out_data;
  logic [SEL_W-1:0] out_ch;
  logic out_valid;
  logic out_ready;
  modport master (
    output mode, sel, in_data, in_valid, out_ready,
    input in_ready, out_data, out_ch, out_valid
  );
  modport slave (
    input mode, sel, in_data, in_valid, out_ready,
    output in_ready, out_data, out_ch, out_valid
  );
endinterface

// File: rtl/stream_mux_rr_pick.sv
// rr_pick: combinational rotate-priority search starting at ptr+1, ptr itself searched last.
module rr_pick #(
  parameter int NUM_CH = 16,
  localparam int SEL_W = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic              gnt_valid,
  output logic [SEL_W-1:0]  gnt_idx
);
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx = '0;
    // walk from the farthest offset inward so the nearest requester wins
    for (int i = NUM_CH; i >= 1; i--) begin
      if (req[(int'(ptr) + i) % NUM_CH]) begin
        gnt_valid = 1'b1;
        gnt_idx = SEL_W'((int'(ptr) + i) % NUM_CH);
      end
    end
  end
endmodule

// File: rtl/stream_mux_rr.sv
// stream_mux_rr: registered N:1 valid/ready stream mux, fixed-select or round-robin.
// Optional transfer counter port xfer_cnt enabled by STREAM_MUX_XFER_COUNT_EN.
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter int NUM_CH = 16,
  parameter int WIDTH = 8
) (
  input logic clk,
  input logic reset,
`ifdef STREAM_MUX_XFER_COUNT_EN
  output logic [XFER_CNT_W-1:0] xfer_cnt,
`endif
  stream_mux_rr_if.slave bus
);
  localparam int SEL_W = $clog2(NUM_CH);
  logic [SEL_W-1:0] ptr, g, rr_idx, out_ch_q;
  logic [WIDTH-1:0] out_data_q;
  logic out_valid_q, rr_valid, fix_ok, grant, load_en, xfer;
  rr_pick #(.NUM_CH(NUM_CH)) u_pick (
    .req(bus.in_valid),
    .ptr(ptr),
    .gnt_valid(rr_valid),
    .gnt_idx(rr_idx)
  );
  always_comb begin
    load_en = !out_valid_q || bus.out_ready;
    fix_ok = (int'(bus.sel) < NUM_CH) && bus.in_valid[bus.sel];
    grant = (bus.mode == MODE_RR) ? rr_valid : fix_ok;
    g = (bus.mode == MODE_RR) ? rr_idx : bus.sel;
    bus.in_ready = (!reset && load_en && grant) ? NUM_CH'(1) << g : '0;
    xfer = |bus.in_ready;
    bus.out_data = out_data_q;
    bus.out_ch = out_ch_q;
    bus.out_valid = out_valid_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q <= '0;
      out_ch_q <= '0;
      ptr <= SEL_W'(NUM_CH - 1);
    end else if (xfer) begin
      out_valid_q <= 1'b1;
      out_data_q <= bus.in_data[g*WIDTH +: WIDTH];
      out_ch_q <= g;
      ptr <= g;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end
`ifdef STREAM_MUX_XFER_COUNT_EN
  always_ff @(posedge clk)
    xfer_cnt <= reset ? '0 : xfer_cnt + XFER_CNT_W'(xfer);
`endif
endmodule

// File: doc/stream_mux_rr.md
Name: stream_mux_rr

Overview:
- Parametrised registered N-channel, W-bit stream multiplexer; successor to the fixed 16:1 single-bit mux in the 8-bit ALU datapath.
- Selects one of NUM_CH valid/ready input channels into a single registered output stage.
- Two modes: fixed select (sel port) or round-robin arbitration. Feeds ALU operand/result routing where multiple sources contend.

Parameters:
- NUM_CH, 16, number of input channels (2..64).
- WIDTH, 8, data width per channel.
- SEL_W, $clog2(NUM_CH), channel index width (localparam, not overridable).

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- mode  input  1  0 = fixed select, 1 = round-robin.
- sel  input  SEL_W  channel index used in mode 0.
- in_data  input  NUM_CH*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- in_valid  input  NUM_CH  per-channel valid.
- in_ready  output  NUM_CH  per-channel ready (combinational).
- out_data  output  WIDTH  registered output data.
- out_ch  output  SEL_W  index of the channel that supplied out_data.
- out_valid  output  1  output holds a beat.
- out_ready  input  1  downstream accepts.

Behaviour:
- Reset: out_valid=0, out_data=0, out_ch=0, rr pointer ptr=NUM_CH-1, so channel 0 has first priority.
- load_en = !out_valid || out_ready. Combinational; no path from in_valid to in_ready of the same channel other than through grant.
- Grant, mode 0: g=sel when in_valid[sel]=1 and sel<NUM_CH; otherwise no grant.
- Grant, mode 1: first channel with in_valid=1, searching ptr+1, ptr+2, … with wrap modulo NUM_CH; ptr itself is searched last. No valid channel gives no grant.
- in_ready[k] = load_en && grant && (k==g). All other ready bits are 0. At most one ready bit is high per cycle.
- Transfer on channel g when in_valid[g] && in_ready[g]:
  - next edge: out_data<=in_data[g], out_ch<=g, out_valid<=1.
  - ptr<=g. ptr updates in both modes.
- Output drain: out_valid && out_ready with no new transfer gives out_valid<=0. out_data and out_ch hold their values.
- Simultaneous drain and load: the new beat replaces the old one in the same edge. Full throughput is 1 beat/cycle, latency 1 cycle.
- Backpressure (out_valid=1, out_ready=0): all in_ready=0. Output is stable and ptr is frozen.
- Mode or sel change: takes effect at the next grant evaluation. A beat already registered is unaffected. ptr is retained across mode changes.
- Reset asserted mid-stream: the registered beat is discarded and all reset values apply at that edge. in_ready is forced 0 while reset=1.
- Fairness: in mode 1 with all channels valid and out_ready=1, grants cycle 0,1,…,NUM_CH-1,0.

Optional Feature:
- Macro STREAM_MUX_XFER_COUNT_EN.
- Defined: adds output port xfer_cnt[15:0]. Reset to 0; increments by 1 on every input transfer; wraps 0xFFFF->0.
- Undefined: port and counter logic are absent. All other behaviour is identical.

Decomposition:
- Package stream_mux_pkg: MODE_FIXED=1'b0, MODE_RR=1'b1, XFER_CNT_W=16.
- Sub-module rr_pick.
  - Parameterised on NUM_CH.
  - Inputs: req[NUM_CH], ptr[SEL_W].
  - Outputs: gnt_valid, gnt_idx.
  - Purely combinational rotate-priority find, instantiated once.

Test Plan:
- Reset then idle: reset=1 for 2 cycles -> out_valid=0, out_data=0, out_ch=0, in_ready=0; after release with no in_valid, in_ready=0.
- Fixed select: mode=0, sel=5, in_valid=16'h0021, ch5 data=8'hA5, out_ready=1 -> in_ready=16'h0020; next cycle out_data=A5, out_ch=5. ch0 is never granted.
- Round-robin fairness: mode=1, all 16 valid, ch k data=k, out_ready=1 -> out_ch sequence 0,1,…,15,0 on consecutive cycles with out_valid continuously 1.
- Backpressure: out_valid=1 holding 8'h3C, out_ready=0 for 4 cycles -> in_ready=0 and out_data=3C stable; out_ready=1 -> next grant is ptr+1.
- Wrap and sparse: mode=1, ptr=14, in_valid=16'h0009 -> grant ch0, then ch3, then ch0.
- Reset mid-stream plus counter (macro defined): 10 transfers -> xfer_cnt=10; reset mid-beat -> out_valid=0, xfer_cnt=0. Preload 65535 transfers, one more -> xfer_cnt=0.
